// File: rtl/acia_rx_fifo.sv
// rtl/acia_rx_fifo.sv - ACIA receive buffer: show-ahead FIFO with sticky flags and IRQ
//
// Purpose: accepts bytes from the serial receiver and holds them for the CPU.
//   One entry is written per rising edge of rx_stb. The head entry is presented
//   combinationally on rd_dat. The block also keeps sticky overrun and framing-error
//   flags and drives a level interrupt request.
//
// Ports:
//   clk, reset_n      system clock, synchronous active-low reset
//   rx_dat, rx_stb    received byte and its data-available strobe (edge-detected)
//   rx_err            framing-error level from receiver (edge-detected)
//   rd                one-cycle pop request; ignored when empty
//   flush             discard all entries
//   clr               clear sticky ovr/ferr (a coincident set event wins)
//   irq_en            interrupt enable
//   rd_dat            head entry, 8'h00 when empty
//   empty, full       fill-level status
//   count             fill level, 0..2**DEPTH_LOG2
//   ovr, ferr         sticky overrun / framing-error flags
//   irq               level interrupt request

module acia_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int IRQ_LEVEL  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_dat,
  input  logic                  rx_stb,
  input  logic                  rx_err,
  input  logic                  rd,
  input  logic                  flush,
  input  logic                  clr,
  input  logic                  irq_en,
  output logic [7:0]            rd_dat,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovr,
  output logic                  ferr,
  output logic                  irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   IRQ_CNT  = (DEPTH_LOG2+1)'(IRQ_LEVEL);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Storage is deliberately not reset; count alone decides which entries are live.
  logic [7:0] mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wp_q, wp_d;
  logic [DEPTH_LOG2-1:0] rp_q, rp_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovr_q, ovr_d;
  logic                  ferr_q, ferr_d;
  logic                  stb_prev_q;
  logic                  err_prev_q;

  logic push;
  logic pop;
  logic ferr_set;
  logic ovr_set;
  logic wr_en;
  logic is_empty;
  logic is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  // A long strobe or error level must only count once, so act on rising edges.
  assign push     = rx_stb & ~stb_prev_q;
  assign ferr_set = rx_err & ~err_prev_q;
  assign pop      = rd & ~is_empty;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovr_set = 1'b0;
    wr_en   = 1'b0;

    if (flush) begin
      // Everything in flight this cycle is dropped, including a push.
      wp_d    = rp_q;
      count_d = '0;
    end else if (push && pop) begin
      // Covers the full case too: the pop frees the slot the push uses.
      wr_en = 1'b1;
      wp_d  = wp_q + PTR_ONE;
      rp_d  = rp_q + PTR_ONE;
    end else if (push && is_full) begin
      ovr_set = 1'b1;
    end else if (push) begin
      wr_en   = 1'b1;
      wp_d    = wp_q + PTR_ONE;
      count_d = count_q + CNT_ONE;
    end else if (pop) begin
      rp_d    = rp_q + PTR_ONE;
      count_d = count_q - CNT_ONE;
    end

    // Set beats clear so an event arriving with clr is never lost.
    ovr_d  = ovr_set  | (ovr_q  & ~clr);
    ferr_d = ferr_set | (ferr_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      stb_prev_q <= 1'b0;
      err_prev_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      stb_prev_q <= rx_stb;
      err_prev_q <= rx_err;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wp_q] <= rx_dat;
    end
  end

  assign rd_dat = is_empty ? 8'h00 : mem_q[rp_q];
  assign empty  = is_empty;
  assign full   = is_full;
  assign count  = count_q;
  assign ovr    = ovr_q;
  assign ferr   = ferr_q;
  assign irq    = irq_en & ((count_q >= IRQ_CNT) | ovr_q | ferr_q);

endmodule

// File: tb/tb_acia_rx_fifo.sv
// tb/tb_acia_rx_fifo.sv - self-checking bench for acia_rx_fifo

module tb_acia_rx_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_dat = 8'h00;
  logic       rx_stb = 1'b0;
  logic       rx_err = 1'b0;
  logic       rd = 1'b0;
  logic       flush = 1'b0;
  logic       clr = 1'b0;
  logic       irq_en = 1'b1;
  logic [7:0] rd_dat;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       ovr;
  logic       ferr;
  logic       irq;

  int n_vec = 0;
  int n_err = 0;

  acia_rx_fifo #(.DEPTH_LOG2(4), .IRQ_LEVEL(1)) dut (
    .clk(clk), .reset_n(reset_n), .rx_dat(rx_dat), .rx_stb(rx_stb),
    .rx_err(rx_err), .rd(rd), .flush(flush), .clr(clr), .irq_en(irq_en),
    .rd_dat(rd_dat), .empty(empty), .full(full), .count(count),
    .ovr(ovr), .ferr(ferr), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       stb;
    logic [7:0] dat;
    logic       err;
    logic       rd;
    logic       fl;
    logic       cl;
    logic       en;
    logic [4:0] e_count;
    logic       e_empty;
    logic       e_full;
    logic [7:0] e_rd;
    logic       e_ovr;
    logic       e_ferr;
    logic       e_irq;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t v(input logic rst_n, input logic stb, input logic [7:0] dat,
                             input logic err, input logic rdi, input logic cl, input logic en,
                             input logic [4:0] c, input logic [7:0] r, input logic fe,
                             input logic iq);
    vec_t t;
    t.rst_n = rst_n; t.stb = stb; t.dat = dat; t.err = err; t.rd = rdi;
    t.fl = 1'b0; t.cl = cl; t.en = en;
    t.e_count = c; t.e_empty = (c == 5'd0); t.e_full = (c == 5'd16);
    t.e_rd = r; t.e_ovr = 1'b0; t.e_ferr = fe; t.e_irq = iq;
    return t;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic step(input logic stb, input logic [7:0] dat, input logic rdi,
                      input logic fl, input logic cl);
    rx_stb = stb; rx_dat = dat; rd = rdi; flush = fl; clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
    step(1'b0, d, 1'b0, 1'b0, 1'b0);
  endtask

  logic [7:0] model_q[$];
  logic [7:0] exp_b;

  initial begin
    //          rst  stb dat    err rd  clr en   count  rd_dat ferr irq
    tbl[0]  = v(0, 0, 8'h00, 0, 0, 0, 1, 5'd0, 8'h00, 0, 0);
    tbl[1]  = v(1, 1, 8'hA5, 0, 0, 0, 1, 5'd1, 8'hA5, 0, 1);
    tbl[2]  = v(1, 1, 8'hA5, 0, 0, 0, 1, 5'd1, 8'hA5, 0, 1);
    tbl[3]  = v(1, 1, 8'hA5, 0, 0, 0, 1, 5'd1, 8'hA5, 0, 1);
    tbl[4]  = v(1, 1, 8'hA5, 0, 0, 0, 1, 5'd1, 8'hA5, 0, 1);
    tbl[5]  = v(1, 1, 8'hA5, 0, 0, 0, 1, 5'd1, 8'hA5, 0, 1);
    tbl[6]  = v(1, 0, 8'h00, 0, 0, 0, 1, 5'd1, 8'hA5, 0, 1);
    tbl[7]  = v(1, 0, 8'h00, 0, 1, 0, 1, 5'd0, 8'h00, 0, 0);
    tbl[8]  = v(1, 0, 8'h00, 0, 1, 0, 1, 5'd0, 8'h00, 0, 0);
    tbl[9]  = v(1, 0, 8'h00, 0, 1, 0, 1, 5'd0, 8'h00, 0, 0);
    tbl[10] = v(1, 0, 8'h00, 0, 1, 0, 1, 5'd0, 8'h00, 0, 0);
    tbl[11] = v(1, 1, 8'h3C, 0, 0, 0, 1, 5'd1, 8'h3C, 0, 1);
    tbl[12] = v(1, 0, 8'h00, 0, 0, 0, 1, 5'd1, 8'h3C, 0, 1);
    tbl[13] = v(1, 0, 8'h00, 0, 1, 0, 1, 5'd0, 8'h00, 0, 0);
    tbl[14] = v(1, 0, 8'h00, 1, 0, 0, 1, 5'd0, 8'h00, 1, 1);
    tbl[15] = v(1, 0, 8'h00, 1, 0, 0, 1, 5'd0, 8'h00, 1, 1);
    tbl[16] = v(1, 0, 8'h00, 0, 0, 0, 1, 5'd0, 8'h00, 1, 1);
    tbl[17] = v(1, 0, 8'h00, 1, 0, 1, 1, 5'd0, 8'h00, 1, 1);
    tbl[18] = v(1, 0, 8'h00, 1, 0, 1, 1, 5'd0, 8'h00, 0, 0);
    tbl[19] = v(1, 0, 8'h00, 0, 0, 0, 1, 5'd0, 8'h00, 0, 0);
    tbl[20] = v(1, 1, 8'h77, 0, 0, 0, 0, 5'd1, 8'h77, 0, 0);
    tbl[21] = v(1, 0, 8'h00, 0, 0, 0, 1, 5'd1, 8'h77, 0, 1);
    tbl[22] = v(1, 0, 8'h00, 0, 1, 0, 1, 5'd0, 8'h00, 0, 0);
    tbl[23] = v(1, 1, 8'h11, 0, 0, 0, 1, 5'd1, 8'h11, 0, 1);
    tbl[24] = v(0, 0, 8'h00, 0, 0, 0, 1, 5'd0, 8'h00, 0, 0);

    for (int i = 0; i < 25; i++) begin
      reset_n = tbl[i].rst_n; rx_err = tbl[i].err; irq_en = tbl[i].en;
      step(tbl[i].stb, tbl[i].dat, tbl[i].rd, tbl[i].fl, tbl[i].cl);
      cmp($sformatf("vec%0d", i),
          32'({count, empty, full, rd_dat, ovr, ferr, irq}),
          32'({tbl[i].e_count, tbl[i].e_empty, tbl[i].e_full, tbl[i].e_rd,
               tbl[i].e_ovr, tbl[i].e_ferr, tbl[i].e_irq}));
    end
    reset_n = 1'b1; rx_err = 1'b0; irq_en = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Fill to full, overrun, drain in order.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    cmp("fill_full", 32'({count, full, ovr}), 32'({5'd16, 1'b1, 1'b0}));
    push_byte(8'hFF);
    cmp("overrun", 32'({count, full, ovr, irq}), 32'({5'd16, 1'b1, 1'b1, 1'b1}));
    for (int i = 0; i < 16; i++) begin
      cmp($sformatf("drain%0d", i), 32'(rd_dat), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    cmp("drained", 32'({count, empty, rd_dat, ovr}), 32'({5'd0, 1'b1, 8'h00, 1'b1}));
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cmp("ovr_clr", 32'({ovr, irq}), 32'({1'b0, 1'b0}));

    // Full FIFO with coincident push and pop.
    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    cmp("full_pushpop", 32'({count, full, ovr}), 32'({5'd16, 1'b1, 1'b0}));
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i == 15) ? 8'h55 : 8'h81 + 8'(i);
      cmp($sformatf("pp_drain%0d", i), 32'(rd_dat), 32'(exp_b));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    cmp("pp_empty", 32'({count, empty, ovr}), 32'({5'd0, 1'b1, 1'b0}));

    // Wrap pointers with push/pop pairs, then flush against a push.
    model_q.delete();
    for (int i = 0; i < 7; i++) begin
      push_byte(8'h10 + 8'(i));
      model_q.push_back(8'h10 + 8'(i));
    end
    for (int k = 0; k < 20; k++) begin
      cmp($sformatf("wrap_head%0d", k), 32'(rd_dat), 32'(model_q[0]));
      step(1'b1, 8'h20 + 8'(k), 1'b1, 1'b0, 1'b0);
      void'(model_q.pop_front());
      model_q.push_back(8'h20 + 8'(k));
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    cmp("wrap_count", 32'({count, rd_dat}), 32'({5'd7, model_q[0]}));
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    cmp("flush", 32'({count, empty, ovr, rd_dat}), 32'({5'd0, 1'b1, 1'b0, 8'h00}));
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cmp("flush_after", 32'({count, empty}), 32'({5'd0, 1'b1}));
    push_byte(8'h6B);
    cmp("post_flush_push", 32'({count, rd_dat}), 32'({5'd1, 8'h6B}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
